// File: rtl/beat_duration_timer_if.sv
// Sequencer-side bundle for the beat duration timer.
// master drives load/duration/pause/count_en; slave reports status.
interface beat_duration_timer_if #(
  parameter int DUR_W = 6
);
  logic             count_en;
  logic             load;
  logic [DUR_W-1:0] duration;
  logic             pause;
  logic             busy;
  logic             done;
  logic [DUR_W-1:0] beats_left;
  logic [DUR_W-1:0] beats_done;

  modport master (
    output count_en,
    output load,
    output duration,
    output pause,
    input  busy,
    input  done,
    input  beats_left,
    input  beats_done
  );

  modport slave (
    input  count_en,
    input  load,
    input  duration,
    input  pause,
    output busy,
    output done,
    output beats_left,
    output beats_done
  );
endinterface

// File: rtl/beat_duration_timer.sv
// Times a loaded duration in beats of the count_en strobe,
// reporting remaining/elapsed beats and pulsing done at expiry.
module beat_duration_timer #(
  parameter int DUR_W = 6
) (
  input logic                 clk,
  input logic                 reset,
  beat_duration_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [DUR_W-1:0] left_q;
  logic [DUR_W-1:0] left_nx;
  logic [DUR_W-1:0] elap_q;
  logic [DUR_W-1:0] elap_nx;
  logic             beat;

  assign beat = bus.count_en & ~bus.pause;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      left_q <= '0;
      elap_q <= '0;
    end else begin
      state  <= state_nx;
      left_q <= left_nx;
      elap_q <= elap_nx;
    end
  end

  // load outranks a beat in the same cycle; FIN and stray codes fall to IDLE
  always_comb begin
    state_nx = (state == RUN) ? RUN : IDLE;
    left_nx  = left_q;
    elap_nx  = elap_q;
    priority case (1'b1)
      bus.load: begin
        left_nx  = bus.duration;
        elap_nx  = '0;
        state_nx = (bus.duration != '0) ? RUN : FIN;
      end
      (state == RUN) && beat && (left_q != '0): begin
        left_nx = left_q - DUR_W'(1);
        elap_nx = elap_q + DUR_W'(1);
        if (left_q == DUR_W'(1))
          state_nx = FIN;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    bus.busy       = (state == RUN);
    bus.done       = (state == FIN);
    bus.beats_left = left_q;
    bus.beats_done = elap_q;
  end

endmodule

// File: tb/tb_beat_duration_timer.sv
// Bench for beat_duration_timer: directed scenarios plus random traffic,
// scoreboarded against a beat-counting reference model.
module tb_beat_duration_timer;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  int   m_rem;
  int   m_el;
  bit   m_run;
  int   exp_q[$];

  beat_duration_timer_if #(.DUR_W(6)) bus ();

  beat_duration_timer #(.DUR_W(6)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic ld, input logic [5:0] d,
                      input logic ps, input logic rs,
                      input logic ce);
    bus.load     = ld;
    bus.duration = d;
    bus.pause    = ps;
    bus.count_en = ce;
    rst_n        = rs;
    @(posedge clk);
    cyc++;
    if (!rs) begin
      m_run = 1'b0;
      m_rem = 0;
      m_el  = 0;
    end else if (ld) begin
      m_rem = int'(d);
      m_el  = 0;
      m_run = (d != 6'd0);
      if (d == 6'd0)
        exp_q.push_back(cyc);
    end else if (m_run && ce && !ps) begin
      m_rem--;
      m_el++;
      if (m_rem == 0) begin
        m_run = 1'b0;
        exp_q.push_back(cyc);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== m_run) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b exp=%b",
               cyc, bus.busy, m_run);
    end
    checks++;
    if (bus.beats_left !== 6'(m_rem)) begin
      errors++;
      $display("FAIL beats_left cyc=%0d got=%0d exp=%0d",
               cyc, bus.beats_left, m_rem);
    end
    checks++;
    if (bus.beats_done !== 6'(m_el)) begin
      errors++;
      $display("FAIL beats_done cyc=%0d got=%0d exp=%0d",
               cyc, bus.beats_done, m_el);
    end
  endtask

  task automatic idle(input int n, input logic ps);
    for (int i = 0; i < n; i++)
      step(1'b0, 6'd0, ps, 1'b1, 1'b0);
  endtask

  task automatic beats(input int n, input logic ps);
    for (int i = 0; i < n; i++) begin
      idle(31, ps);
      step(1'b0, 6'd0, ps, 1'b1, 1'b1);
    end
  endtask

  task automatic ld(input logic [5:0] d, input logic ce);
    step(1'b1, d, 1'b0, 1'b1, ce);
  endtask

  // done monitor: every pulse must match the next expected expiry cycle
  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0] < cyc) begin
      errors++;
      $display("FAIL done_missing due=%0d now=%0d got=0 exp=1",
               exp_q[0], cyc);
      void'(exp_q.pop_front());
    end
    if (bus.done !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0] != cyc) begin
        errors++;
        $display("FAIL done_unexpected cyc=%0d got=%b exp=0",
                 cyc, bus.done);
      end else begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [5:0] d;
    cyc    = 0;
    checks = 0;
    errors = 0;
    m_rem  = 0;
    m_el   = 0;
    m_run  = 1'b0;
    bus.load     = 1'b0;
    bus.duration = '0;
    bus.pause    = 1'b0;
    bus.count_en = 1'b0;
    rst_n        = 1'b0;

    step(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    beats(2, 1'b0);

    ld(6'd3, 1'b0);
    beats(4, 1'b0);

    ld(6'd4, 1'b0);
    beats(1, 1'b0);
    beats(1, 1'b1);
    beats(3, 1'b0);

    ld(6'd0, 1'b0);
    ld(6'd2, 1'b0);
    beats(3, 1'b0);

    ld(6'd5, 1'b0);
    beats(2, 1'b0);
    idle(31, 1'b0);
    ld(6'd2, 1'b1);
    beats(3, 1'b0);

    ld(6'd6, 1'b0);
    beats(3, 1'b0);
    step(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    beats(2, 1'b0);

    ld(6'd63, 1'b0);
    beats(64, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0)
        d = 6'($urandom_range(0, 63));
      else
        d = 6'($urandom_range(0, 10));
      step(($urandom_range(0, 39) == 0), d,
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 499) != 0),
           ($urandom_range(0, 5) == 0));
    end
    idle(4, 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL done_pending got=%0d exp=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
